// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 16-entry FIFO built on an external single-port RAM with a
// combinational read and a write on the rising edge. Only one RAM access
// happens per cycle. A one-entry output register holds the head word.
// When a push and a read both want the RAM, the one that was not granted
// last time wins.
module ram_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_last_op;   // 0: last grant was a write, 1: a read

  logic w_rd_want;
  logic w_wr_ready;
  logic w_wr_go;
  logic w_rd_go;

  // Grant logic: a read is wanted when the RAM holds data and the output
  // register is empty or is being consumed this cycle. A push must yield
  // to a wanted read if the previous grant was a write.
  always_comb begin
    w_rd_want  = (r_count != '0) && (!r_rd_valid || rd_ready);
    w_wr_ready = (r_count != L_FULL) && !(w_rd_want && !r_last_op);
    w_wr_go    = wr_valid && w_wr_ready;
    w_rd_go    = w_rd_want && !w_wr_go;
  end

  // Pointer, count, output register and arbitration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_last_op  <= 1'b0;
    end else begin
      if (w_wr_go) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_count   <= r_count + (AW+1)'(1);
        r_last_op <= 1'b0;
      end
      if (w_rd_go) begin
        r_rd_data  <= ram_rdata;
        r_rd_valid <= 1'b1;
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_count    <= r_count - (AW+1)'(1);
        r_last_op  <= 1'b1;
      end else if (r_rd_valid && rd_ready) begin
        // Head consumed with nothing to refill it; data is left as is.
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign wr_ready  = w_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign count     = r_count;
  assign ram_rw    = w_wr_go;
  assign ram_addr  = w_wr_go ? r_wr_ptr : r_rd_ptr;
  assign ram_wdata = wr_data;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: a behavioural 16x8 RAM, a scoreboard monitor,
// and directed scenarios followed by a long randomised push/pop run.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic [3:0] ram_addr;
  logic       ram_rw;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [16];
  logic [7:0] q [$];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DW(8), .AW(4), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .count     (count),
    .ram_addr  (ram_addr),
    .ram_rw    (ram_rw),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM: write on rising edge, combinational read.
  always @(posedge clk) if (ram_rw) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: sampled mid-cycle; checks occupancy, the full condition
  // and pop ordering, then records this cycle's handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      check_value("occupancy", 32'(count) + 32'(rd_valid), 32'(q.size()));
      if (q.size() - int'(rd_valid) == 16) check_value("full_no_push", 32'(wr_ready), 0);
      check_value("capacity", 32'(q.size() <= 17), 1);
      if (rd_valid && rd_ready) begin
        if (q.size() == 0) check_value("pop_on_empty", 1, 0);
        else check_value("pop_data", 32'(rd_data), 32'(q.pop_front()));
      end
      if (wr_valid && wr_ready) q.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] v);
    logic ok;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_data  = v;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1 ok = wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    check_value("push_accept", 32'(ok), 1);
    $display("push 0x%02h accepted=%0d", v, ok);
  endtask

  task automatic drain(input int max_cycles);
    rd_ready = 1'b1;
    wr_valid = 1'b0;
    for (int n = 0; n < max_cycles && q.size() != 0; n++) tick();
    check_value("drain_empty", 32'(q.size()), 0);
    check_value("drain_rd_valid", 32'(rd_valid), 0);
    rd_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    logic [4:0] held_count;
    logic [7:0] next_word;
    logic       ok;
    int         k;
    int         pw;
    int         pr;

    // ---- 1: reset values, then reset mid-stream ----
    #1 rst = 1'b1;
    #1;
    check_value("rst0_count", 32'(count), 0);
    check_value("rst0_rd_valid", 32'(rd_valid), 0);
    check_value("rst0_ram_rw", 32'(ram_rw), 0);
    tick(); tick();
    rst = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    check_value("pre_rst_rd_valid", 32'(rd_valid), 1);
    check_value("pre_rst_count", 32'(count), 2);
    #2 rst = 1'b1;
    #1;
    check_value("rst_count", 32'(count), 0);
    check_value("rst_rd_valid", 32'(rd_valid), 0);
    check_value("rst_rd_data", 32'(rd_data), 0);
    check_value("rst_ram_rw", 32'(ram_rw), 0);
    q.delete();
    tick(); tick();
    rst = 1'b0;

    // ---- 2: single push, two-cycle latency, first address 0 ----
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    #1;
    check_value("t2_ram_rw_w", 32'(ram_rw), 1);
    check_value("t2_ram_addr_w", 32'(ram_addr), 0);
    tick();
    wr_valid = 1'b0;
    #1;
    check_value("t2_ram_rw_r", 32'(ram_rw), 0);
    check_value("t2_ram_addr_r", 32'(ram_addr), 0);
    check_value("t2_rd_valid_early", 32'(rd_valid), 0);
    tick();
    check_value("t2_rd_valid", 32'(rd_valid), 1);
    check_value("t2_rd_data", 32'(rd_data), 32'h A5);
    $display("pop 0xa5");
    tick();
    check_value("t2_rd_valid_after", 32'(rd_valid), 0);
    rd_ready = 1'b0;

    // ---- 3: fill to DEPTH+1, refuse 18th, drain with wrap ----
    for (int i = 0; i <= 16; i++) push_word(8'(i));
    check_value("t3_rd_data", 32'(rd_data), 0);
    check_value("t3_count", 32'(count), 16);
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    #1;
    check_value("t3_full_wr_ready", 32'(wr_ready), 0);
    tick();
    wr_valid = 1'b0;
    drain(60);

    // ---- 4: steady push + pop alternates W,R with 4..5 entries ----
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'h20 + 8'(i));
    rd_ready = 1'b1;
    tick();
    check_value("t4_start_count", 32'(count), 4);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h30 + 8'(k);
      #1;
      check_value("t4_ram_rw", 32'(ram_rw), (i % 2 == 0) ? 1 : 0);
      check_value("t4_count", 32'(count), (i % 2 == 0) ? 4 : 5);
      ok = wr_ready;
      $display("t4 cycle %0d grant=%s count=%0d", i, ram_rw ? "W" : "R", count);
      tick();
      if (ok) k++;
    end
    wr_valid = 1'b0;

    // ---- 5: stall holds the head word, release gives next word ----
    rd_ready = 1'b0;
    tick();
    held       = rd_data;
    held_count = count;
    check_value("t5_rd_valid", 32'(rd_valid), 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_value("t5_hold_data", 32'(rd_data), 32'(held));
      check_value("t5_hold_valid", 32'(rd_valid), 1);
      check_value("t5_hold_count", 32'(count), 32'(held_count));
      check_value("t5_hold_rw", 32'(ram_rw), 0);
      tick();
    end
    next_word = q[1];
    rd_ready = 1'b1;
    tick();
    check_value("t5_next_valid", 32'(rd_valid), 1);
    check_value("t5_next_data", 32'(rd_data), 32'(next_word));
    $display("pop 0x%02h then 0x%02h", held, next_word);
    drain(60);

    // ---- 6: randomised push/pop against the scoreboard ----
    for (int c = 0; c < 10000; c++) begin
      if (c < 2500)      begin pw = 85; pr = 15; end
      else if (c < 5000) begin pw = 20; pr = 80; end
      else if (c < 7500) begin pw = 50; pr = 50; end
      else               begin pw = 70; pr = 60; end
      wr_valid = (($urandom % 100) < 32'(pw));
      rd_ready = (($urandom % 100) < 32'(pr));
      wr_data  = 8'($urandom);
      tick();
    end
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
